// File: rtl/ava_pkg.sv
// Shared AVA width constants.
//   LINEAR_COORDS_BITS : width of a linear pixel coordinate
//   VRAM_ADDR_WIDTH    : width of a 32-bit VRAM word address (coords >> 2)
package ava_pkg;
    localparam int unsigned LINEAR_COORDS_BITS = 16;
    localparam int unsigned VRAM_ADDR_WIDTH    = 14;
endpackage

// File: rtl/ava_pixel_writer_if.sv
// Bus bundle for ava_pixel_writer: pixel stream from the drawing/CPU side
// plus the byte-enabled VRAM write port.
//   px_valid/px_ready  : pixel handshake, transfer when both high at clk rise
//   px_coords          : linear pixel coordinate
//   px_index           : 8-bit palette index
//   px_last            : flush buffer after this pixel
//   vram_a/vram_d      : VRAM word address / write data
//   vram_we            : byte enables, non-zero means write request
//   vram_gnt           : VRAM accepts the pending write this cycle
// modport master: system side (drives pixels and grant)
// modport slave : the pixel writer
interface ava_pixel_writer_if;
    import ava_pkg::*;

    logic                          px_valid;
    logic                          px_ready;
    logic [LINEAR_COORDS_BITS-1:0] px_coords;
    logic [7:0]                    px_index;
    logic                          px_last;
    logic [VRAM_ADDR_WIDTH-1:0]    vram_a;
    logic [31:0]                   vram_d;
    logic [3:0]                    vram_we;
    logic                          vram_gnt;

    modport master (
        output px_valid, px_coords, px_index, px_last, vram_gnt,
        input  px_ready, vram_a, vram_d, vram_we
    );

    modport slave (
        input  px_valid, px_coords, px_index, px_last, vram_gnt,
        output px_ready, vram_a, vram_d, vram_we
    );
endinterface

// File: rtl/ava_pixel_writer.sv
// ava_pixel_writer: packs 8-bit palette indices four per 32-bit VRAM word
// (lane k = coords[1:0] at bits 8k+7:8k) and issues byte-enabled writes.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : ava_pixel_writer_if.slave (pixel stream + VRAM write port)
//   busy  : buffer holds data or a write is pending
module ava_pixel_writer
    import ava_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    ava_pixel_writer_if.slave   bus,
    output logic                busy
);

    typedef enum logic [1:0] {EMPTY, FILL, WRITE} state_t;

    state_t                     state, state_nx;
    logic [31:0]                word_q;
    logic [3:0]                 mask_q;
    logic [VRAM_ADDR_WIDTH-1:0] addr_q;

    logic [VRAM_ADDR_WIDTH-1:0] px_word;
    logic [1:0]                 px_lane;
    logic [3:0]                 lane_bit;
    logic                       addr_match;
    logic                       ready_c;
    logic                       accept;

    always_comb begin
        px_word    = VRAM_ADDR_WIDTH'(bus.px_coords >> 2);
        px_lane    = bus.px_coords[1:0];
        lane_bit   = 4'b0001 << px_lane;
        addr_match = (px_word == addr_q);
    end

    // In FILL a pixel for another word is refused and triggers the flush;
    // it is re-offered by the source once the buffer is EMPTY again.
    always_comb begin
        state_nx = state;
        ready_c  = 1'b0;
        unique case (state)
            EMPTY: begin
                ready_c = 1'b1;
                if (bus.px_valid)
                    state_nx = bus.px_last ? WRITE : FILL;
            end
            FILL: begin
                if (bus.px_valid) begin
                    if (addr_match) begin
                        ready_c = 1'b1;
                        if (((mask_q | lane_bit) == 4'b1111) || bus.px_last)
                            state_nx = WRITE;
                    end else begin
                        state_nx = WRITE;
                    end
                end
            end
            WRITE: begin
                if (bus.vram_gnt)
                    state_nx = EMPTY;
            end
            default: state_nx = EMPTY;
        endcase
    end

    assign accept = bus.px_valid && ready_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= EMPTY;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            mask_q <= '0;
            addr_q <= '0;
        end else if (accept) begin
            if (state == EMPTY) begin
                addr_q <= px_word;
                mask_q <= lane_bit;
            end else begin
                mask_q <= mask_q | lane_bit;
            end
            word_q[{px_lane, 3'b000} +: 8] <= bus.px_index;
        end else if ((state == WRITE) && bus.vram_gnt) begin
            mask_q <= '0;
        end
    end

    // vram_we is gated by the state register so an async reset drops it at once.
    assign bus.px_ready = ready_c;
    assign bus.vram_a   = addr_q;
    assign bus.vram_d   = word_q;
    assign bus.vram_we  = (state == WRITE) ? mask_q : 4'b0000;
    assign busy         = (state != EMPTY);

endmodule

// File: tb/tb_ava_pixel_writer.sv
module tb_ava_pixel_writer;
    import ava_pkg::*;

    localparam int CB = LINEAR_COORDS_BITS;
    localparam int AW = VRAM_ADDR_WIDTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    always #5 clk = ~clk;

    ava_pixel_writer_if bus();

    ava_pixel_writer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit gnt_rand = 1'b0;
    int acc_cyc;

    logic [AW-1:0] wq_a[$];
    logic [31:0]   wq_d[$];
    logic [3:0]    wq_we[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Records every write that the VRAM port retires at the following edge.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.vram_we !== 4'b0000 && bus.vram_gnt === 1'b1) begin
            wq_a.push_back(bus.vram_a);
            wq_d.push_back(bus.vram_d);
            wq_we.push_back(bus.vram_we);
        end
    end

    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{we[b]}};
        return m;
    endfunction

    task automatic get_write(output logic [AW-1:0] a, output logic [31:0] d, output logic [3:0] we);
        if (wq_a.size() > 0) begin
            a = wq_a.pop_front(); d = wq_d.pop_front(); we = wq_we.pop_front();
        end else begin
            a = '1; d = '0; we = '0;
        end
    endtask

    // Offers one pixel and holds it until accepted; returns refused cycles.
    task automatic send_px(input logic [CB-1:0] c, input logic [7:0] idx, input logic last, output int waits);
        bit done = 1'b0;
        bus.px_valid = 1'b1; bus.px_coords = c; bus.px_index = idx; bus.px_last = last;
        waits = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.px_ready === 1'b1) done = 1'b1;
            else waits++;
            @(posedge clk); #1;
            if (done) acc_cyc = cyc;
            if (gnt_rand) bus.vram_gnt = 1'($urandom_range(0, 1));
            if (done) break;
        end
        bus.px_valid = 1'b0; bus.px_last = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_px_timeout coords=%0d got no accept, required accept", c);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
            if (gnt_rand) bus.vram_gnt = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_reset();
        bus.px_valid = 1'b0; bus.px_coords = '0; bus.px_index = '0; bus.px_last = 1'b0;
        bus.vram_gnt = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.vram_we !== 4'b0000) $display("FAIL rst_we_during got=%b exp=0000", bus.vram_we); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.vram_a !== '0) $display("FAIL rst_vram_a got=%0h exp=0", bus.vram_a); else n_pass++;
        n_checks++; if (bus.vram_d !== 32'h0) $display("FAIL rst_vram_d got=%h exp=0", bus.vram_d); else n_pass++;
        n_checks++; if (bus.vram_we !== 4'b0000) $display("FAIL rst_vram_we got=%b exp=0000", bus.vram_we); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (bus.px_ready !== 1'b1) $display("FAIL rst_px_ready got=%b exp=1", bus.px_ready); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_full_word();
        int w, nlow;
        bit ok;
        logic [AW-1:0] a; logic [31:0] d; logic [3:0] we;
        bus.vram_gnt = 1'b1;
        nlow = 0;
        for (int i = 0; i < 4; i++) begin
            send_px(CB'(i), 8'(8'h11 * (i + 1)), 1'b0, w);
            nlow += w;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.px_ready !== 1'b1) nlow++;
            @(posedge clk); #1;
        end
        n_checks++; if (nlow != 1) $display("FAIL full_ready_low_cycles got=%0d exp=1", nlow); else n_pass++;
        wait_idle(ok);
        n_checks++; if (wq_a.size() != 1) $display("FAIL full_write_count got=%0d exp=1", wq_a.size()); else n_pass++;
        get_write(a, d, we);
        n_checks++; if (a !== AW'(0)) $display("FAIL full_vram_a got=%0h exp=0", a); else n_pass++;
        n_checks++; if (d !== 32'h44332211) $display("FAIL full_vram_d got=%h exp=44332211", d); else n_pass++;
        n_checks++; if (we !== 4'b1111) $display("FAIL full_vram_we got=%b exp=1111", we); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int w, first;
        bit ok;
        logic [7:0] v[8];
        logic [AW-1:0] a; logic [31:0] d; logic [3:0] we;
        bus.vram_gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v[i] = 8'($urandom);
            send_px(CB'(32 + i), v[i], 1'b0, w);
            if (i == 0) first = acc_cyc;
        end
        n_checks++; if (acc_cyc - first != 8) $display("FAIL b2b_cycles got=%0d exp=8", acc_cyc - first); else n_pass++;
        wait_idle(ok);
        n_checks++; if (wq_a.size() != 2) $display("FAIL b2b_write_count got=%0d exp=2", wq_a.size()); else n_pass++;
        for (int j = 0; j < 2; j++) begin
            get_write(a, d, we);
            n_checks++;
            if (a !== AW'(8 + j) || we !== 4'b1111 || d !== {v[4*j+3], v[4*j+2], v[4*j+1], v[4*j]})
                $display("FAIL b2b_write%0d got a=%0h d=%h we=%b exp a=%0h d=%h we=1111", j, a, d, we,
                         8 + j, {v[4*j+3], v[4*j+2], v[4*j+1], v[4*j]});
            else n_pass++;
        end
    endtask

    task automatic test_partial_flush();
        int w;
        bit ok;
        logic [AW-1:0] a; logic [31:0] d; logic [3:0] we;
        bus.vram_gnt = 1'b1;
        send_px(CB'(5), 8'hAA, 1'b1, w);
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL partial_idle got=busy exp=idle"); else n_pass++;
        get_write(a, d, we);
        n_checks++; if (a !== AW'(1)) $display("FAIL partial_vram_a got=%0h exp=1", a); else n_pass++;
        n_checks++; if (we !== 4'b0010) $display("FAIL partial_vram_we got=%b exp=0010", we); else n_pass++;
        n_checks++; if (d[15:8] !== 8'hAA) $display("FAIL partial_vram_d got=%h exp=AA", d[15:8]); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || bus.px_ready !== 1'b1)
            $display("FAIL partial_after got busy=%b ready=%b exp busy=0 ready=1", busy, bus.px_ready);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_address_jump();
        int w1, w2;
        bit ok;
        logic [AW-1:0] a; logic [31:0] d; logic [3:0] we;
        bus.vram_gnt = 1'b1;
        send_px(CB'(8), 8'h01, 1'b0, w1);
        send_px(CB'(20), 8'h02, 1'b1, w2);
        n_checks++; if (w2 != 2) $display("FAIL jump_holdoff_cycles got=%0d exp=2", w2); else n_pass++;
        wait_idle(ok);
        n_checks++; if (wq_a.size() != 2) $display("FAIL jump_write_count got=%0d exp=2", wq_a.size()); else n_pass++;
        get_write(a, d, we);
        n_checks++; if (a !== AW'(2) || we !== 4'b0001 || d[7:0] !== 8'h01)
            $display("FAIL jump_write0 got a=%0h we=%b d0=%h exp a=2 we=0001 d0=01", a, we, d[7:0]);
        else n_pass++;
        get_write(a, d, we);
        n_checks++; if (a !== AW'(5) || we !== 4'b0001 || d[7:0] !== 8'h02)
            $display("FAIL jump_write1 got a=%0h we=%b d0=%h exp a=5 we=0001 d0=02", a, we, d[7:0]);
        else n_pass++;
    endtask

    task automatic test_grant_stall();
        int w, nlow;
        bit stable, ok;
        logic [AW-1:0] a0; logic [31:0] d0; logic [3:0] we0;
        logic [AW-1:0] a; logic [31:0] d; logic [3:0] we;
        logic [7:0] v[4];
        bus.vram_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v[i] = 8'($urandom);
            send_px(CB'(12 + i), v[i], 1'b0, w);
        end
        stable = 1'b1; nlow = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin a0 = bus.vram_a; d0 = bus.vram_d; we0 = bus.vram_we; end
            else if (bus.vram_a !== a0 || bus.vram_d !== d0 || bus.vram_we !== we0) stable = 1'b0;
            if (bus.px_ready === 1'b0) nlow++;
            @(posedge clk); #1;
        end
        n_checks++; if (we0 !== 4'b1111 || a0 !== AW'(3) || d0 !== {v[3], v[2], v[1], v[0]})
            $display("FAIL stall_pending got a=%0h d=%h we=%b exp a=3 d=%h we=1111", a0, d0, we0, {v[3], v[2], v[1], v[0]});
        else n_pass++;
        n_checks++; if (!stable) $display("FAIL stall_stable got=changed exp=held"); else n_pass++;
        n_checks++; if (nlow != 3) $display("FAIL stall_ready_low got=%0d exp=3", nlow); else n_pass++;
        n_checks++; if (wq_a.size() != 0) $display("FAIL stall_early_write got=%0d exp=0", wq_a.size()); else n_pass++;
        bus.vram_gnt = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        n_checks++; if (wq_a.size() != 1) $display("FAIL stall_retire got=%0d exp=1", wq_a.size()); else n_pass++;
        get_write(a, d, we);
        n_checks++; if (d !== {v[3], v[2], v[1], v[0]}) $display("FAIL stall_vram_d got=%h exp=%h", d, {v[3], v[2], v[1], v[0]}); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || bus.px_ready !== 1'b1 || bus.vram_we !== 4'b0000)
            $display("FAIL stall_after got busy=%b ready=%b we=%b exp 0 1 0000", busy, bus.px_ready, bus.vram_we);
        else n_pass++;
        @(posedge clk); #1;
        wait_idle(ok);
    endtask

    task automatic test_lane_overwrite();
        int w;
        bit ok;
        logic [AW-1:0] a; logic [31:0] d; logic [3:0] we;
        bus.vram_gnt = 1'b1;
        send_px(CB'(4), 8'h01, 1'b0, w);
        send_px(CB'(4), 8'h02, 1'b1, w);
        wait_idle(ok);
        n_checks++; if (wq_a.size() != 1) $display("FAIL ovw_write_count got=%0d exp=1", wq_a.size()); else n_pass++;
        get_write(a, d, we);
        n_checks++; if (a !== AW'(1) || we !== 4'b0001 || d[7:0] !== 8'h02)
            $display("FAIL ovw_write got a=%0h we=%b d0=%h exp a=1 we=0001 d0=02", a, we, d[7:0]);
        else n_pass++;
    endtask

    task automatic test_reset_in_write();
        int w, nq;
        bus.vram_gnt = 1'b0;
        for (int i = 0; i < 4; i++) send_px(CB'(i), 8'(8'hA0 + i), 1'b0, w);
        @(negedge clk);
        n_checks++; if (bus.vram_we !== 4'b1111) $display("FAIL rstw_pending got=%b exp=1111", bus.vram_we); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus.vram_we !== 4'b0000) $display("FAIL rstw_we_async got=%b exp=0000", bus.vram_we); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstw_busy_async got=%b exp=0", busy); else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        nq = wq_a.size();
        bus.vram_gnt = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || bus.px_ready !== 1'b1)
            $display("FAIL rstw_after got busy=%b ready=%b exp busy=0 ready=1", busy, bus.px_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (wq_a.size() != nq) $display("FAIL rstw_no_write got=%0d exp=%0d", wq_a.size(), nq); else n_pass++;
    endtask

    task automatic test_random();
        logic [CB-1:0] pc[40];
        logic [7:0]    pv[40];
        bit            pl[40];
        logic [AW-1:0] ea[$];
        logic [31:0]   ed[$];
        logic [3:0]    ew[$];
        logic [AW-1:0] wd, ga, wa, a;
        logic [31:0]   gd, d;
        logic [3:0]    gm, we;
        logic [1:0]    lane;
        bit            open, ok;
        int            w, p, nexp;
        for (int t = 0; t < 4; t++) begin
            wq_a.delete(); wq_d.delete(); wq_we.delete();
            ea.delete(); ed.delete(); ew.delete();
            wd = '0;
            for (int i = 0; i < 40; i++) begin
                if (i == 0 || $urandom_range(0, 3) == 0) begin
                    p = int'($urandom_range(0, 4));
                    wd = (p == 4) ? '1 : AW'(p);
                end
                pc[i] = {wd, 2'($urandom_range(0, 3))};
                pv[i] = 8'($urandom);
                pl[i] = (i == 39) || ($urandom_range(0, 5) == 0);
            end
            // Expected writes: pixels sharing a word coalesce until the word
            // is complete, px_last is seen, or a pixel for another word arrives.
            open = 1'b0; ga = '0; gd = '0; gm = '0;
            for (int i = 0; i < 40; i++) begin
                wa = pc[i][CB-1:2];
                lane = pc[i][1:0];
                if (open && wa != ga) begin
                    ea.push_back(ga); ed.push_back(gd); ew.push_back(gm); open = 1'b0;
                end
                if (!open) begin ga = wa; gd = '0; gm = '0; open = 1'b1; end
                gd[lane*8 +: 8] = pv[i];
                gm[lane] = 1'b1;
                if (gm == 4'b1111 || pl[i]) begin
                    ea.push_back(ga); ed.push_back(gd); ew.push_back(gm); open = 1'b0;
                end
            end
            gnt_rand = 1'b1;
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    bus.vram_gnt = 1'($urandom_range(0, 1));
                end
                send_px(pc[i], pv[i], pl[i], w);
            end
            wait_idle(ok);
            gnt_rand = 1'b0;
            n_checks++; if (!ok) $display("FAIL rand%0d_idle got=busy exp=idle", t); else n_pass++;
            nexp = ea.size();
            n_checks++; if (wq_a.size() != nexp) $display("FAIL rand%0d_count got=%0d exp=%0d", t, wq_a.size(), nexp); else n_pass++;
            for (int j = 0; j < nexp; j++) begin
                get_write(a, d, we);
                n_checks++;
                if (a !== ea[j] || we !== ew[j] || (d & lane_mask(ew[j])) !== (ed[j] & lane_mask(ew[j])))
                    $display("FAIL rand%0d_write%0d got a=%0h d=%h we=%b exp a=%0h d=%h we=%b",
                             t, j, a, d & lane_mask(ew[j]), we, ea[j], ed[j] & lane_mask(ew[j]), ew[j]);
                else n_pass++;
            end
        end
        bus.vram_gnt = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_back_to_back();
        test_partial_flush();
        test_address_jump();
        test_grant_stall();
        test_lane_overwrite();
        test_reset_in_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ava_pixel_writer.md
# ava_pixel_writer

Write-side counterpart to the direct-mode scan-out path. It accepts a stream of 8-bit palette indices addressed by linear pixel coordinate and packs them four per 32-bit VRAM word. It then issues byte-enabled word writes to the VRAM write port. It sits between the drawing/CPU side of AVA and VRAM, and produces the same byte layout that direct-mode scan-out consumes.

## Interface
- No parameters. Widths come from `ava_pkg`: `LINEAR_COORDS_BITS` and `VRAM_ADDR_WIDTH`.
- `clk`  in  1  — single clock; everything is synchronous to its rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `px_valid`  in  1  — pixel offered.
- `px_ready`  out  1  — pixel accepted when `px_valid && px_ready` at a rising edge.
- `px_coords`  in  `LINEAR_COORDS_BITS`  — linear pixel coordinate.
- `px_index`  in  8  — palette index to store.
- `px_last`  in  1  — flush the buffer after this pixel.
- `vram_a`  out  `VRAM_ADDR_WIDTH`  — word address.
- `vram_d`  out  32  — write data.
- `vram_we`  out  4  — byte write enables; a non-zero value means a write request.
- `vram_gnt`  in  1  — VRAM port accepts the pending write in this cycle.
- `busy`  out  1  — buffer holds data or a write is pending.

## Operation
- Word address is `px_coords >> 2`. Byte lane k = `px_coords[1:0]`, placed at `vram_d[8k +: 8]` (little-endian within the word).
- Internal state:
  - word buffer (32b), byte mask (4b), buffered word address;
  - FSM states EMPTY, FILL, WRITE.
- EMPTY:
  - `px_ready`=1.
  - On accept: load the address, set the lane byte and its mask bit, go to FILL.
  - If the accepted pixel is the only pixel needed to flush (`px_last`), go directly to WRITE.
- FILL, `px_valid` with a matching word address:
  - accept, write the lane byte and set its mask bit;
  - a repeated lane overwrites the byte (last write wins).
- FILL, `px_valid` with a different word address:
  - `px_ready`=0 (combinational on `px_valid`/`px_coords`);
  - go to WRITE without accepting; the pixel is re-offered after the flush.
- FILL → WRITE when, after an accept, the mask is 4'b1111 or `px_last` was set.
- WRITE:
  - `px_ready`=0; `vram_a`/`vram_d`/`vram_we` are driven from registers and held stable until `vram_gnt`.
  - On `vram_gnt`: clear the mask and go to EMPTY.
- `vram_we` = mask in WRITE, 0 in every other state. Bytes with a clear mask bit are don't-care on `vram_d`.
- `busy` = (state != EMPTY).
- No read-modify-write: lanes that were not written are preserved in VRAM through the byte enables.

## Timing
- Reset values:
  - state EMPTY;
  - `vram_we`=0, `vram_a`=0, `vram_d`=0, mask 0, `busy`=0;
  - `px_ready`=1 once `reset` deasserts; no transfer is recognised while `reset` is high.
- Accept that completes the mask or carries `px_last`: `vram_we` is non-zero from the next cycle.
- Address-mismatch flush: WRITE is entered one cycle after the mismatch is first presented.
- Write retires in the cycle with `vram_gnt`=1. Next cycle: EMPTY, `px_ready`=1, `vram_we`=0.
- With `vram_gnt` tied high, peak throughput is 4 pixels per 5 cycles (4 accepts plus 1 write cycle).
- `vram_gnt` is ignored outside WRITE.
- Reset mid-operation, including in WRITE: the buffer is dropped and `vram_we` falls to 0 immediately (asynchronous). No partial write is issued.
- `px_last` on a pixel that fills the mask produces a single write, not two.

## Test plan
- Full word: coords 0,1,2,3 with indices 0x11,0x22,0x33,0x44, `vram_gnt`=1 → one write with `vram_a`=0, `vram_d`=0x44332211, `vram_we`=4'b1111; `px_ready` low exactly one cycle.
- Partial flush: coord 5, index 0xAA, `px_last`=1 → `vram_a`=1, `vram_we`=4'b0010, `vram_d[15:8]`=0xAA; then `busy`=0.
- Address jump: coord 8 (index 0x01), then coord 20 (index 0x02, `px_last`) → first write `vram_a`=2, `vram_we`=4'b0001; coord 20 is held off by `px_ready`=0 and then accepted; second write `vram_a`=5, `vram_we`=4'b0001, `vram_d[7:0]`=0x02.
- Grant stall: fill a word, hold `vram_gnt`=0 for 3 cycles → `vram_a`/`vram_d`/`vram_we` constant and `px_ready`=0 throughout; retire on the 4th cycle.
- Lane overwrite: coord 4 with 0x01, then coord 4 with 0x02 and `px_last` → `vram_we`=4'b0001, `vram_d[7:0]`=0x02.
- Reset in WRITE: with `vram_we`=4'b1111 and `vram_gnt`=0, assert `reset` → `vram_we`=0 in the same cycle; after release, `busy`=0 and `px_ready`=1, and no write occurs.
